// File: rtl/hazard_unit_if.sv
// Pipeline hazard interface: stage register indices/enables in, stall/flush/forward controls out.
// The pipeline side drives the "master" modport; the hazard unit uses "slave".
interface hazard_unit_if #(parameter int CNT_W = 16);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic [4:0]       ex_rs;
   logic [4:0]       ex_rt;
   logic [4:0]       ex_rd;
   logic             ex_regwrite;
   logic             ex_memread;
   logic [4:0]       mem_rd;
   logic             mem_regwrite;
   logic [4:0]       wb_rd;
   logic             wb_regwrite;
   logic             branch_taken;
   logic             jump_taken;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken, jump_taken,
      input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
             fwd_a, fwd_b, state, stall_count, flush_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
             mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken, jump_taken,
      output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush,
             fwd_a, fwd_b, state, stall_count, flush_count
   );
endinterface

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard unit: combinational stall/flush/forward controls, observational FSM, perf counters.
// Optional macro FORWARD_EN: enables EX operand forwarding and limits stalls to load-use.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input logic         clk,
   input logic         rst_n,
   hazard_unit_if.slave hif
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t state_q;
   state_t state_d;

   logic             hazard;
   logic             redirect;
   logic             stall_act;
   logic [1:0]       fwd_a_c;
   logic [1:0]       fwd_b_c;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst, input logic we);
      return we && (src == dst) && (dst != 5'd0);
   endfunction

   function automatic logic id_reads(input logic [4:0] dst, input logic we);
      return reg_match(hif.id_rs, dst, we) || (hif.id_uses_rt && reg_match(hif.id_rt, dst, we));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] src);
      if (reg_match(src, hif.mem_rd, hif.mem_regwrite))
         return 2'b10;
      else if (reg_match(src, hif.wb_rd, hif.wb_regwrite))
         return 2'b01;
      else
         return 2'b00;
   endfunction

`ifdef FORWARD_EN
   assign hazard  = id_reads(hif.ex_rd, hif.ex_regwrite && hif.ex_memread);
   assign fwd_a_c = fwd_sel(hif.ex_rs);
   assign fwd_b_c = fwd_sel(hif.ex_rt);
`else
   // Without forwarding the consumer waits until its producer has written back.
   assign hazard  = id_reads(hif.ex_rd, hif.ex_regwrite)
                 || id_reads(hif.mem_rd, hif.mem_regwrite)
                 || id_reads(hif.wb_rd, hif.wb_regwrite);
   assign fwd_a_c = 2'b00;
   assign fwd_b_c = 2'b00;
`endif

   assign redirect  = hif.branch_taken || hif.jump_taken;
   assign stall_act = hazard && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = RUN;
      if (redirect)
         state_d = FLUSH;
      else if (hazard)
         state_d = STALL;
   end

   always_comb begin
      hif.pc_write    = 1'b1;
      hif.ifid_write  = 1'b1;
      hif.ifid_flush  = 1'b0;
      hif.idex_flush  = 1'b0;
      hif.exmem_flush = 1'b0;
      hif.fwd_a       = fwd_a_c;
      hif.fwd_b       = fwd_b_c;
      if (!rst_n) begin
         hif.pc_write    = 1'b0;
         hif.ifid_write  = 1'b0;
         hif.ifid_flush  = 1'b1;
         hif.idex_flush  = 1'b1;
         hif.exmem_flush = 1'b1;
         hif.fwd_a       = 2'b00;
         hif.fwd_b       = 2'b00;
      end else if (redirect) begin
         hif.ifid_flush  = 1'b1;
         hif.idex_flush  = 1'b1;
         hif.exmem_flush = 1'b1;
      end else if (hazard) begin
         hif.pc_write    = 1'b0;
         hif.ifid_write  = 1'b0;
         hif.idex_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_act && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
         if (redirect && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign hif.state       = state_q;
   assign hif.stall_count = stall_cnt_q;
   assign hif.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench for hazard_unit: directed pipeline scenarios plus random vectors vs. a rule-level model.
module tb_hazard_unit;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_unit_if #(.CNT_W(CW)) hif ();
   hazard_unit #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));

   typedef struct {
      logic       rst_n;
      logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
      logic       id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
      logic       branch_taken, jump_taken;
   } stim_t;

   typedef struct {
      logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
      logic [1:0] fwd_a, fwd_b, state;
      int         stall_cnt, flush_cnt;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   done = 0;

   int   m_state = 0;
   int   m_stall = 0;
   int   m_flush = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst_n: 1'b1, default: '0};
      return s;
   endfunction

   function automatic bit dep(input int src, input int dst, input bit we);
      return we && src == dst && dst != 0;
   endfunction

   function automatic int fwd_of(input stim_t s, input int src);
      if (dep(src, s.mem_rd, s.mem_regwrite)) return 2;
      if (dep(src, s.wb_rd, s.wb_regwrite)) return 1;
      return 0;
   endfunction

   function automatic exp_t model(input stim_t s);
      exp_t e;
      int   wr_rd[$];
      bit   wr_we[$];
      bit   hz = 0;
      bit   redir;
`ifdef FORWARD_EN
      wr_rd.push_back(s.ex_rd);  wr_we.push_back(s.ex_regwrite && s.ex_memread);
      e.fwd_a = 2'(fwd_of(s, s.ex_rs));
      e.fwd_b = 2'(fwd_of(s, s.ex_rt));
`else
      wr_rd.push_back(s.ex_rd);  wr_we.push_back(s.ex_regwrite);
      wr_rd.push_back(s.mem_rd); wr_we.push_back(s.mem_regwrite);
      wr_rd.push_back(s.wb_rd);  wr_we.push_back(s.wb_regwrite);
      e.fwd_a = 2'b00;
      e.fwd_b = 2'b00;
`endif
      foreach (wr_rd[i])
         if (dep(s.id_rs, wr_rd[i], wr_we[i]) || (s.id_uses_rt && dep(s.id_rt, wr_rd[i], wr_we[i])))
            hz = 1;
      redir = s.branch_taken || s.jump_taken;
      e.pc_write    = redir || !hz;
      e.ifid_write  = redir || !hz;
      e.ifid_flush  = redir;
      e.idex_flush  = redir || hz;
      e.exmem_flush = redir;
      e.state       = 2'(m_state);
      e.stall_cnt   = m_stall;
      e.flush_cnt   = m_flush;
      if (!s.rst_n) begin
         e = '{pc_write: 0, ifid_write: 0, ifid_flush: 1, idex_flush: 1, exmem_flush: 1,
               fwd_a: 0, fwd_b: 0, state: 0, stall_cnt: 0, flush_cnt: 0};
      end
      return e;
   endfunction

   // Drive on the falling edge; the model's registered view advances for the coming rising edge.
   task automatic apply(input stim_t s);
      exp_t e;
      bit   hz_only;
      @(negedge clk);
      rst_n = s.rst_n;
      hif.id_rs = s.id_rs;   hif.id_rt = s.id_rt;   hif.id_uses_rt = s.id_uses_rt;
      hif.ex_rs = s.ex_rs;   hif.ex_rt = s.ex_rt;   hif.ex_rd = s.ex_rd;
      hif.ex_regwrite = s.ex_regwrite;  hif.ex_memread = s.ex_memread;
      hif.mem_rd = s.mem_rd; hif.mem_regwrite = s.mem_regwrite;
      hif.wb_rd = s.wb_rd;   hif.wb_regwrite = s.wb_regwrite;
      hif.branch_taken = s.branch_taken; hif.jump_taken = s.jump_taken;
      if (!s.rst_n) begin
         m_state = 0; m_stall = 0; m_flush = 0;
      end
      e = model(s);
      exp_q.push_back(e);
      if (s.rst_n) begin
         hz_only = e.idex_flush && !e.exmem_flush;
         m_state = e.exmem_flush ? 2 : (hz_only ? 1 : 0);
         if (hz_only && m_stall < SAT) m_stall++;
         if (e.exmem_flush && m_flush < SAT) m_flush++;
      end
   endtask

   task automatic chk(input string name, input int got, input int want);
      if (got != want) begin
         miscompares++;
         $display("FAIL %s vec=%0d got=%0d want=%0d", name, vectors, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("pc_write",    int'(hif.pc_write),    int'(e.pc_write));
            chk("ifid_write",  int'(hif.ifid_write),  int'(e.ifid_write));
            chk("ifid_flush",  int'(hif.ifid_flush),  int'(e.ifid_flush));
            chk("idex_flush",  int'(hif.idex_flush),  int'(e.idex_flush));
            chk("exmem_flush", int'(hif.exmem_flush), int'(e.exmem_flush));
            chk("fwd_a",       int'(hif.fwd_a),       int'(e.fwd_a));
            chk("fwd_b",       int'(hif.fwd_b),       int'(e.fwd_b));
            chk("state",       int'(hif.state),       int'(e.state));
            chk("stall_count", int'(hif.stall_count), e.stall_cnt);
            chk("flush_count", int'(hif.flush_count), e.flush_cnt);
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      stim_t r;
      s = idle();
      s.rst_n = 0;
      apply(s); apply(s);

      // lw $2 in EX, add $3,$2,$4 in ID; then bubble, then add reaches EX with lw in WB
      s = idle(); s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1;
      s.ex_rd = 2; s.ex_regwrite = 1; s.ex_memread = 1; apply(s);
      s = idle(); s.id_rs = 2; s.id_rt = 4; s.id_uses_rt = 1;
      s.mem_rd = 2; s.mem_regwrite = 1; apply(s);
      s = idle(); s.ex_rs = 2; s.ex_rt = 4; s.wb_rd = 2; s.wb_regwrite = 1; apply(s);

      // add $2 then sub $5,$2,$2 back to back
      s = idle(); s.id_rs = 2; s.id_rt = 2; s.id_uses_rt = 1;
      s.ex_rd = 2; s.ex_regwrite = 1; apply(s);
      s = idle(); s.ex_rs = 2; s.ex_rt = 2; s.mem_rd = 2; s.mem_regwrite = 1; apply(s);

      // add $2 then add $3,$2,$0 with the producer walking EX -> MEM -> WB
      s = idle(); s.id_rs = 2; s.id_uses_rt = 1; s.ex_rd = 2; s.ex_regwrite = 1; apply(s);
      s = idle(); s.id_rs = 2; s.id_uses_rt = 1; s.mem_rd = 2; s.mem_regwrite = 1; apply(s);
      s = idle(); s.id_rs = 2; s.id_uses_rt = 1; s.wb_rd = 2; s.wb_regwrite = 1; apply(s);
      s = idle(); s.ex_rs = 2; apply(s);

      // load-use hazard coincident with a taken branch, then a jump
      s = idle(); s.id_rs = 7; s.ex_rd = 7; s.ex_regwrite = 1; s.ex_memread = 1;
      s.branch_taken = 1; apply(s);
      s.branch_taken = 0; s.jump_taken = 1; apply(s);
      apply(idle());

      // writer to $0 with a consumer reading $0
      s = idle(); s.ex_rd = 0; s.ex_regwrite = 1; s.ex_memread = 1;
      s.mem_rd = 0; s.mem_regwrite = 1; s.wb_rd = 0; s.wb_regwrite = 1;
      s.id_uses_rt = 1; apply(s);

      // drive both counters into saturation and beyond
      s = idle(); s.id_rs = 9; s.ex_rd = 9; s.ex_regwrite = 1; s.ex_memread = 1;
      for (int i = 0; i < SAT + 4; i++) apply(s);
      s.branch_taken = 1;
      for (int i = 0; i < SAT + 4; i++) apply(s);
      s.branch_taken = 0;
      apply(s); apply(s);

      // reset asserted mid-stall, then released with the hazard still present
      s.rst_n = 0; apply(s);
      s.rst_n = 1; apply(s); apply(s);
      apply(idle());

      for (int i = 0; i < 400; i++) begin
         r = idle();
         r.id_rs = 5'($urandom_range(0, 3));  r.id_rt = 5'($urandom_range(0, 3));
         r.ex_rs = 5'($urandom_range(0, 3));  r.ex_rt = 5'($urandom_range(0, 3));
         r.ex_rd = 5'($urandom_range(0, 3));  r.mem_rd = 5'($urandom_range(0, 3));
         r.wb_rd = 5'($urandom_range(0, 3));
         r.id_uses_rt = 1'($urandom);  r.ex_regwrite = 1'($urandom);
         r.ex_memread = 1'($urandom);  r.mem_regwrite = 1'($urandom);
         r.wb_regwrite = 1'($urandom);
         r.branch_taken = ($urandom_range(0, 7) == 0);
         r.jump_taken   = ($urandom_range(0, 9) == 0);
         r.rst_n        = ($urandom_range(0, 39) != 0);
         apply(r);
      end

      repeat (3) @(negedge clk);
      #4;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      if (vectors < 12) begin
         miscompares++;
         $display("FAIL coverage vectors=%0d want>=12", vectors);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs and id_rt, input, 5 each: source registers of the instruction in IF/ID.
REQ-005 SHALL have port id_uses_rt, input, 1: the ID instruction reads rt (R-type, beq, sw).
REQ-006 SHALL have ports ex_rs and ex_rt, input, 5 each: source registers held in ID/EX.
REQ-007 SHALL have ports ex_rd (5), ex_regwrite (1) and ex_memread (1), inputs: ID/EX destination after the RegDst mux, write enable, and load flag.
REQ-008 SHALL have ports mem_rd (5) and mem_regwrite (1), inputs: EX/MEM destination and write enable.
REQ-009 SHALL have ports wb_rd (5) and wb_regwrite (1), inputs: MEM/WB destination and write enable.
REQ-010 SHALL have ports branch_taken and jump_taken, input, 1 each: EX/MEM Branch&ZF and the EX/MEM jump bit.
REQ-011 SHALL have outputs pc_write and ifid_write, 1 each: PC and IF/ID load enables.
REQ-012 SHALL have outputs ifid_flush, idex_flush and exmem_flush, 1 each: replace the stage contents with a bubble.
REQ-013 SHALL have outputs fwd_a and fwd_b, 2 each: ALU operand source selects.
REQ-014 SHALL have output state, 2: current FSM state.
REQ-015 SHALL have outputs stall_count and flush_count, CNT_W each: performance counters.

Function
REQ-016 A register match SHALL require equal 5-bit indices, the writer's regwrite=1, and a nonzero index; register 0 never matches.
REQ-017 A hazard SHALL exist when id_rs matches, or id_uses_rt=1 and id_rt matches, a writer given by REQ-030/031.
REQ-018 redirect = branch_taken | jump_taken.
REQ-019 On redirect: pc_write=1, ifid_write=1, and all three flushes =1 in the same cycle; redirect has priority over a hazard.
REQ-020 On a hazard without redirect: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0, exmem_flush=0.
REQ-021 Otherwise: pc_write=1, ifid_write=1, all flushes =0.
REQ-022 FSM states SHALL be RUN=00, STALL=01, FLUSH=10.
REQ-023 Next state is FLUSH if redirect, else STALL if hazard, else RUN; this is evaluated every cycle from any state.
REQ-024 The state value SHALL reflect the previous cycle's decision and is observational only; the REQ-019..021 outputs are combinational from current inputs.
REQ-025 stall_count SHALL increment once per cycle with REQ-020 active; it saturates at all-ones.
REQ-026 flush_count SHALL increment once per redirect cycle; it saturates at all-ones.

Reset
REQ-027 While rst_n=0, the block SHALL drive state=RUN, both counters 0, pc_write=0, ifid_write=0, all flushes =1, and fwd_a=fwd_b=00.
REQ-028 Reset SHALL take effect immediately, including mid-stall or mid-flush; the first edge after release evaluates from RUN.
REQ-029 All state SHALL reside in flops reset by rst_n.

Configuration
REQ-030 With FORWARD_EN defined, forwarding SHALL be compiled in:
- fwd_a selects by ex_rs: 10 on an EX/MEM match (mem_rd), else 01 on a MEM/WB match (wb_rd), else 00; EX/MEM wins.
- fwd_b is the same, using ex_rt.
- The hazard writer set is only ex_rd with ex_memread=1 (load-use), giving exactly one stall cycle.
REQ-031 Without FORWARD_EN:
- fwd_a=fwd_b=00 always.
- The hazard writer set is ex_rd, mem_rd and wb_rd, so a dependent instruction stalls until its producer leaves WB (up to 3 cycles).

Verification
REQ-032 Bench SHALL cover:
- FORWARD_EN: lw $2 then add $3,$2,$4 -> exactly one cycle with pc_write=0, idex_flush=1; then fwd_a=01; stall_count=1.
- FORWARD_EN: add $2 then sub $5,$2,$2 back-to-back -> no stall; fwd_a=fwd_b=10 in sub's EX cycle.
- No FORWARD_EN: add $2 then add $3,$2,$0 -> 3 stall cycles; stall_count=3; fwd=00.
- Hazard coincident with branch_taken=1 -> all flushes =1, pc_write=1, state=FLUSH next; stall_count unchanged, flush_count +1.
- Writer rd=0 with regwrite=1 and a consumer reading $0 -> no stall, fwd=00.
- rst_n low during STALL -> immediate REQ-027 values; counters preloaded to all-ones -> stay all-ones on further events.
